osd_wb_sram_resp: RTL
=====================

# osd_wb_sram_resp

Wishbone B3 slave memory: the responder for Wishbone masters such as the MAM Wishbone interface. It serves classic single-beat cycles and incrementing or wrapping bursts, with a configurable number of wait states and an error response for out-of-range addresses. It sits on the system-side Wishbone bus as debug-target memory and acts as a bring-up and regression responder for MAM access paths.

## Interface
- DATA_WIDTH, 32: data bus width in bits; allowed values are 8, 16 and 32. SW = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- BASE_ADDR, 0: byte address of word 0; must be SW-aligned.
- MEM_WORDS, 1024: memory depth in words.
- WAIT_STATES, 1: cycles inserted before the first ack of each cycle; range 0..15.
- clk_i  in  1  clock; all logic is single-clock.
- rst_ni  in  1  reset; synchronous, active-low.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  strobe.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  SW  byte enables.
- cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; any other value is treated as classic.
- bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination (address out of range).
- dat_o  out  DATA_WIDTH  read data.

## Operation
- Word index = (addr - BASE_ADDR) >> log2(SW); the low log2(SW) address bits are ignored.
- An address is in range iff addr >= BASE_ADDR and index < MEM_WORDS.
- States: IDLE, WAIT, RESP. There is a 4-bit wait counter and a latched byte address cur_addr.
- IDLE:
  - On a cycle with cyc_i & stb_i: latch cur_addr = addr_i and we = we_i.
  - If WAIT_STATES == 0, go to RESP; otherwise load the counter with WAIT_STATES and go to WAIT.
- WAIT:
  - Counter decrements each cycle; when it is 1, go to RESP.
  - !cyc_i or !stb_i: go to IDLE (abort).
- RESP: the termination qualifier is term = cyc_i & stb_i.
  - ack_o = term & in_range(cur_addr); err_o = term & !in_range(cur_addr). ack_o and err_o are never both 1.
  - Write: on the edge with ack_o = 1, write each byte lane b where sel_i[b] = 1 with dat_i lane b. Lanes with sel_i = 0 are unchanged.
  - Read: dat_o holds mem[cur_addr] for the whole RESP cycle. Its value is loaded when entering RESP and on each burst advance.
  - err: no write is performed and dat_o = 0.
  - After termination with cti_i == 010: stay in RESP and advance cur_addr by SW.
    - bte 00: linear advance.
    - Wrap bursts: only the low log2(beats) word-index bits increment and wrap; the upper bits are held (wrap-4: beats = 4, etc.).
  - After termination with any other cti_i: go to IDLE.
  - cyc_i & !stb_i in RESP with cti 010: stay in RESP (master wait); no ack, no write.
  - !cyc_i in RESP: go to IDLE with no write.
- Burst beats after the first carry no wait states.
- Classic cycles are always followed by at least one cycle with ack_o = 0.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, ack_o = 0, err_o = 0, dat_o = 0, counter = 0, cur_addr = 0.
- Reset asserted in any state: return to IDLE the next cycle. A pending write is discarded.
- Latency: request sampled at edge T, then ack_o/err_o is high in the cycle after edge T+WAIT_STATES. With WAIT_STATES = 0 this is 1 cycle.
- Classic cycle throughput: one transfer per WAIT_STATES+2 cycles.
- Burst: the master holds stb_i high, and ack_o repeats on consecutive cycles until the 111 beat. The write of beat k and the read of beat k+1 occur on the same edge with no conflict.
- Read-after-write to the same word, as separate cycles, returns the new data.
- Linear-burst address increment past the last word: the next beat gives err_o. A burst that has once errored keeps erroring until it ends.
- addr_i is sampled only in IDLE. Changes of addr_i during WAIT or RESP are ignored.

## Test plan
- Classic write then read, WAIT_STATES = 2:
  - write 0xDEADBEEF to BASE+0x10, sel 1111: ack_o goes high 3 cycles after the strobe and lasts exactly 1 cycle.
  - read of BASE+0x10: dat_o = 0xDEADBEEF with ack_o.
- Byte enables: memory word 0x11223344; write 0xAABBCCDD with sel 0101 → readback 0x11BB33DD.
- Linear burst, WAIT_STATES = 0: read 4 beats from BASE+0x0 (cti 010, 010, 010, 111) → ack_o high for 4 consecutive cycles; dat_o = mem[0..3] in order.
- Wrap-4 burst: read starting at word index 6, 4 beats → word indices 6, 7, 4, 5.
- Error response with MEM_WORDS = 16:
  - read of BASE+0x40 → err_o for 1 cycle, ack_o = 0, dat_o = 0.
  - write to the same address → memory unchanged.
- Abort and reset, WAIT_STATES = 3:
  - drop cyc_i during WAIT → no ack, no write.
  - rst_ni low for 1 cycle during RESP of a write → that write is not committed; all outputs 0 the next cycle.

Source files
------------

// File: rtl/osd_wb_sram_resp.sv
// Wishbone B3 slave memory with classic, incrementing and wrapping bursts,
// programmable wait states before the first ack and err for out-of-range addresses.
module osd_wb_sram_resp #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           MEM_WORDS   = 1024,
    parameter int unsigned           WAIT_STATES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);

    localparam int unsigned           SW         = DATA_WIDTH / 8;
    localparam int unsigned           LSB        = $clog2(SW);
    localparam int unsigned           IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] WORDS_A    = ADDR_WIDTH'(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK   = ADDR_WIDTH'(SW - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);
    localparam logic [3:0]            WS_LOAD    = 4'(WAIT_STATES);
    localparam logic [2:0]            CTI_INCR   = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic                    we_q;
    logic                    rng_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    logic                    term;
    logic                    req_rng_d;
    logic [ADDR_WIDTH-1:0]   next_addr_d;
    logic                    next_rng_d;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> LSB) < WORDS_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] word;
        word = (a - BASE_ADDR) >> LSB;
        return word[IDX_W-1:0];
    endfunction

    // Wrap bursts increment only the low word-index bits inside the wrap window.
    function automatic logic [ADDR_WIDTH-1:0] burst_next(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [1:0]            bte);
        logic [ADDR_WIDTH-1:0] off;
        logic [ADDR_WIDTH-1:0] word;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] word_n;
        off  = a - BASE_ADDR;
        word = off >> LSB;
        case (bte)
            2'b01:   mask = ADDR_WIDTH'(3);
            2'b10:   mask = ADDR_WIDTH'(7);
            2'b11:   mask = ADDR_WIDTH'(15);
            default: mask = '1;
        endcase
        word_n = (word & ~mask) | ((word + ONE_A) & mask);
        return BASE_ADDR + ((word_n << LSB) | (off & LOW_MASK));
    endfunction

    assign term        = (state_q == ST_RESP) && cyc_i && stb_i;
    assign ack_o       = term && rng_q;
    assign err_o       = term && !rng_q;
    assign dat_o       = dat_q;
    assign req_rng_d   = in_range(addr_i);
    assign next_addr_d = burst_next(cur_addr_q, bte_i);
    // Once a burst has errored it keeps erroring, even if the address wraps back.
    assign next_rng_d  = rng_q && in_range(next_addr_d);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_addr_q <= '0;
            we_q       <= 1'b0;
            rng_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cyc_i && stb_i) begin
                        cur_addr_q <= addr_i;
                        we_q       <= we_i;
                        rng_q      <= req_rng_d;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                            dat_q   <= req_rng_d ? mem[word_idx(addr_i)] : '0;
                        end else begin
                            cnt_q   <= WS_LOAD;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!cyc_i || !stb_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                        dat_q   <= rng_q ? mem[word_idx(cur_addr_q)] : '0;
                    end
                end
                ST_RESP: begin
                    if (!cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (stb_i) begin
                        if (cti_i == CTI_INCR) begin
                            cur_addr_q <= next_addr_d;
                            rng_q      <= next_rng_d;
                            dat_q      <= next_rng_d ? mem[word_idx(next_addr_d)] : '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; clearing it would need a per-word
    // reset path and contents are defined as undefined after reset anyway.
    always_ff @(posedge clk_i) begin
        if (rst_ni && ack_o && we_q) begin
            for (int b = 0; b < SW; b++) begin
                if (sel_i[b]) begin
                    mem[word_idx(cur_addr_q)][b*8 +: 8] <= dat_i[b*8 +: 8];
                end
            end
        end
    end

endmodule
